// File: rtl/ysyx_210247_mem_bridge_pkg.sv
// Shared constants for the cache-line to AXI4 memory bridge.
// Line geometry, AXI encodings and the line-alignment helper.
package ysyx_210247_mem_bridge_pkg;

  localparam int          RW_DATA_WIDTH  = 128;
  localparam logic [63:0] ZERO_WORD      = 64'h0;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0]  AXI_LEN_LINE   = 8'd1;

  function automatic logic [31:0] line_addr(
    input logic [31:0] a
  );
    return {a[31:4], 4'b0};
  endfunction

endpackage

// File: rtl/ysyx_210247_mem_bridge.sv
// Cache line fill / write-back bridge onto a 64-bit AXI4 port.
// One flat FSM, one outstanding burst of two beats, 128-bit line buffer.
module ysyx_210247_mem_bridge
  import ysyx_210247_mem_bridge_pkg::*;
#(
  parameter int                  AXI_ID_W = 4,
  parameter logic [AXI_ID_W-1:0] AXI_ID   = 4'd0
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic [31:0]              mem_req_addr,
  input  logic [RW_DATA_WIDTH-1:0] mem_req_data,
  input  logic                     mem_req_wen,
  input  logic [1:0]               mem_req_size,
  input  logic [7:0]               mem_req_strb,
  input  logic                     mem_req_valid,
  output logic                     mem_resp_valid,
  output logic [RW_DATA_WIDTH-1:0] mem_resp_data,

  output logic                     aw_valid,
  input  logic                     aw_ready,
  output logic [31:0]              aw_addr,
  output logic [AXI_ID_W-1:0]      aw_id,
  output logic [7:0]               aw_len,
  output logic [2:0]               aw_size,
  output logic [1:0]               aw_burst,

  output logic                     w_valid,
  input  logic                     w_ready,
  output logic [63:0]              w_data,
  output logic [7:0]               w_strb,
  output logic                     w_last,

  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [1:0]               b_resp,

  output logic                     ar_valid,
  input  logic                     ar_ready,
  output logic [31:0]              ar_addr,
  output logic [AXI_ID_W-1:0]      ar_id,
  output logic [7:0]               ar_len,
  output logic [2:0]               ar_size,
  output logic [1:0]               ar_burst,

  input  logic                     r_valid,
  output logic                     r_ready,
  input  logic [63:0]              r_data,
  input  logic [1:0]               r_resp,
  input  logic                     r_last,

  output logic                     bus_err
);

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WDATA,
    WRESP,
    RADDR,
    RDATA,
    RESP,
    RELEASE
  } state_t;

  state_t                   state;
  logic [RW_DATA_WIDTH-1:0] data_q;
  logic [RW_DATA_WIDTH-1:0] line_q;
  logic [RW_DATA_WIDTH-1:0] line_nxt;
  logic                     beat_q;
  logic                     dropped;
  logic                     keep;
  logic                     unused_inputs;

  assign unused_inputs = ^{mem_req_size, mem_req_strb,
                           mem_req_addr[3:0]};

  assign aw_id    = AXI_ID;
  assign aw_len   = AXI_LEN_LINE;
  assign aw_size  = AXI_SIZE_8B;
  assign aw_burst = AXI_BURST_INCR;
  assign ar_id    = AXI_ID;
  assign ar_len   = AXI_LEN_LINE;
  assign ar_size  = AXI_SIZE_8B;
  assign ar_burst = AXI_BURST_INCR;

  assign w_strb = 8'hFF;
  assign w_data = beat_q ? data_q[127:64] : data_q[63:0];
  assign w_last = w_valid & beat_q;

  // A request that dropped at any point gets no completion pulse.
  assign keep = mem_req_valid & ~dropped;

  always_comb begin
    line_nxt = line_q;
    if (beat_q) line_nxt[127:64] = r_data;
    else        line_nxt[63:0]   = r_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      data_q         <= '0;
      line_q         <= '0;
      beat_q         <= 1'b0;
      dropped        <= 1'b0;
      mem_resp_valid <= 1'b0;
      mem_resp_data  <= '0;
      aw_valid       <= 1'b0;
      aw_addr        <= '0;
      w_valid        <= 1'b0;
      b_ready        <= 1'b0;
      ar_valid       <= 1'b0;
      ar_addr        <= '0;
      r_ready        <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      mem_resp_valid <= 1'b0;
      if (!mem_req_valid) dropped <= 1'b1;
      if ((b_valid && b_ready && b_resp != AXI_RESP_OKAY) ||
          (r_valid && r_ready && r_resp != AXI_RESP_OKAY))
        bus_err <= 1'b1;
      unique case (state)
        IDLE: begin
          if (mem_req_valid) begin
            data_q  <= mem_req_data;
            line_q  <= '0;
            beat_q  <= 1'b0;
            dropped <= 1'b0;
            if (mem_req_wen) begin
              aw_addr  <= line_addr(mem_req_addr);
              aw_valid <= 1'b1;
              state    <= WADDR;
            end else begin
              ar_addr  <= line_addr(mem_req_addr);
              ar_valid <= 1'b1;
              state    <= RADDR;
            end
          end
        end
        WADDR: begin
          if (aw_ready) begin
            aw_valid <= 1'b0;
            w_valid  <= 1'b1;
            state    <= WDATA;
          end
        end
        WDATA: begin
          if (w_ready) begin
            beat_q <= ~beat_q;
            if (beat_q) begin
              w_valid <= 1'b0;
              b_ready <= 1'b1;
              state   <= WRESP;
            end
          end
        end
        WRESP: begin
          if (b_valid) begin
            b_ready        <= 1'b0;
            mem_resp_valid <= keep;
            mem_resp_data  <= {ZERO_WORD, ZERO_WORD};
            state          <= RESP;
          end
        end
        RADDR: begin
          if (ar_ready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            state    <= RDATA;
          end
        end
        RDATA: begin
          if (r_valid) begin
            beat_q <= ~beat_q;
            line_q <= line_nxt;
            if (r_last) begin
              r_ready        <= 1'b0;
              mem_resp_valid <= keep;
              mem_resp_data  <= keep ? line_nxt : '0;
              state          <= RESP;
            end
          end
        end
        RESP: begin
          mem_resp_data <= '0;
          state         <= dropped ? IDLE : RELEASE;
        end
        RELEASE: begin
          if (!mem_req_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_210247_mem_bridge.sv
// Directed bench for the line bridge: fill, write-back, stalls,
// held request, bus error, dropped request and mid-burst reset.
module tb_ysyx_210247_mem_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_req_wen;
  logic [1:0]   mem_req_size;
  logic [7:0]   mem_req_strb;
  logic         mem_req_valid;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic         aw_valid, aw_ready;
  logic [31:0]  aw_addr;
  logic [3:0]   aw_id;
  logic [7:0]   aw_len;
  logic [2:0]   aw_size;
  logic [1:0]   aw_burst;
  logic         w_valid, w_ready;
  logic [63:0]  w_data;
  logic [7:0]   w_strb;
  logic         w_last;
  logic         b_valid, b_ready;
  logic [1:0]   b_resp;
  logic         ar_valid, ar_ready;
  logic [31:0]  ar_addr;
  logic [3:0]   ar_id;
  logic [7:0]   ar_len;
  logic [2:0]   ar_size;
  logic [1:0]   ar_burst;
  logic         r_valid, r_ready;
  logic [63:0]  r_data;
  logic [1:0]   r_resp;
  logic         r_last;
  logic         bus_err;

  int checks = 0;
  int errors = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0, resp_n = 0, stab_viol = 0;
  int snap;

  always #5 clk = ~clk;

  ysyx_210247_mem_bridge dut (
    .clk(clk), .rst(rst),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_wen(mem_req_wen), .mem_req_size(mem_req_size),
    .mem_req_strb(mem_req_strb), .mem_req_valid(mem_req_valid),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .aw_id(aw_id), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .ar_id(ar_id), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last),
    .bus_err(bus_err)
  );

  logic        pv_aw, pv_w, p_w_last;
  logic [31:0] p_aw_addr;
  logic [63:0] p_w_data;

  always @(posedge clk) begin
    if (rst) begin
      pv_aw = 1'b0;
      pv_w  = 1'b0;
    end else begin
      if (aw_valid && aw_ready) aw_hs++;
      if (w_valid && w_ready) w_hs++;
      if (ar_valid && ar_ready) ar_hs++;
      if (mem_resp_valid) resp_n++;
      if (aw_valid && ar_valid) stab_viol++;
      if (pv_aw && !(aw_valid && aw_addr == p_aw_addr)) stab_viol++;
      if (pv_w && !(w_valid && w_data == p_w_data &&
                    w_last == p_w_last)) stab_viol++;
      pv_aw     = aw_valid && !aw_ready;
      p_aw_addr = aw_addr;
      pv_w      = w_valid && !w_ready;
      p_w_data  = w_data;
      p_w_last  = w_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    mem_req_addr = '0; mem_req_data = '0; mem_req_wen = 1'b0;
    mem_req_size = 2'b11; mem_req_strb = 8'hFF; mem_req_valid = 1'b0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00;
    r_last = 1'b0;
    tick(); tick();
    chk("rst_valids", {aw_valid, w_valid, b_ready, ar_valid, r_ready,
                       mem_resp_valid, bus_err}, '0);
    chk("rst_resp_data", mem_resp_data, '0);
    chk("rst_addr", {aw_addr, ar_addr}, '0);
    chk("rst_const", {aw_len, aw_size, aw_burst, ar_len, ar_size,
                      ar_burst, aw_id, ar_id},
        {8'd1, 3'b011, 2'b01, 8'd1, 3'b011, 2'b01, 4'd0, 4'd0});
    rst = 1'b0;
    tick();

    // Fill
    mem_req_addr = 32'h8000_1238; mem_req_wen = 1'b0;
    mem_req_valid = 1'b1; ar_ready = 1'b1;
    tick();
    mem_req_addr = 32'h1234_5678;
    chk("fill_ar", {ar_valid, aw_valid, ar_addr, ar_len},
        {1'b1, 1'b0, 32'h8000_1230, 8'd1});
    tick();
    chk("fill_rready", {r_ready, ar_valid}, {1'b1, 1'b0});
    r_valid = 1'b1; r_data = 64'h1111; r_last = 1'b0;
    tick();
    chk("fill_no_early", mem_resp_valid, 1'b0);
    r_data = 64'h2222; r_last = 1'b1;
    tick();
    r_valid = 1'b0; r_last = 1'b0;
    chk("fill_resp", {mem_resp_valid, mem_resp_data},
        {1'b1, 64'h2222, 64'h1111});
    mem_req_valid = 1'b0;
    tick();
    chk("fill_one_pulse", mem_resp_valid, 1'b0);
    tick();

    // Write-back
    mem_req_addr = 32'h8000_2004; mem_req_wen = 1'b1;
    mem_req_data = 128'hAAAAAAAA_AAAAAAAA_55555555_55555555;
    mem_req_valid = 1'b1; aw_ready = 1'b1; w_ready = 1'b1;
    tick();
    mem_req_data = '0;
    chk("wb_aw", {aw_valid, ar_valid, aw_addr}, {1'b1, 1'b0, 32'h8000_2000});
    tick();
    chk("wb_beat0", {w_valid, w_last, w_strb, w_data},
        {1'b1, 1'b0, 8'hFF, 64'h55555555_55555555});
    tick();
    chk("wb_beat1", {w_valid, w_last, w_data},
        {1'b1, 1'b1, 64'hAAAAAAAA_AAAAAAAA});
    tick();
    chk("wb_bready", {w_valid, b_ready, mem_resp_valid}, {1'b0, 1'b1, 1'b0});
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    chk("wb_resp", {mem_resp_valid, mem_resp_data}, {1'b1, 128'h0});
    mem_req_valid = 1'b0;
    tick(); tick();

    // Backpressure on AW and W
    aw_ready = 1'b0; w_ready = 1'b0;
    mem_req_addr = 32'h8000_4010;
    mem_req_data = 128'h0123456789ABCDEF_FEDCBA9876543210;
    mem_req_valid = 1'b1;
    snap = w_hs;
    tick();
    tick(); tick(); tick();
    chk("bp_aw_held", {aw_valid, aw_addr}, {1'b1, 32'h8000_4010});
    aw_ready = 1'b1;
    tick();
    aw_ready = 1'b0;
    for (int i = 0; i < 20 && !b_ready; i++) begin
      w_ready = i[0];
      tick();
    end
    w_ready = 1'b0;
    chk("bp_reach_wresp", b_ready, 1'b1);
    chk("bp_two_beats", 32'(w_hs - snap), 32'd2);
    snap = resp_n;
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    mem_req_valid = 1'b0;
    tick(); tick();
    chk("bp_one_resp", 32'(resp_n - snap), 32'd1);
    chk("bp_stable", 32'(stab_viol), 32'd0);

    // Request dropped mid-transaction
    aw_ready = 1'b1; w_ready = 1'b1;
    mem_req_addr = 32'h8000_5000; mem_req_valid = 1'b1;
    tick();
    mem_req_valid = 1'b0;
    tick(); tick(); tick();
    snap = resp_n;
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    chk("drop_no_pulse", mem_resp_valid, 1'b0);
    tick(); tick();
    chk("drop_count", 32'(resp_n - snap), 32'd0);

    // Held request, then error response
    mem_req_addr = 32'h8000_6008; mem_req_wen = 1'b0;
    mem_req_valid = 1'b1; ar_ready = 1'b1;
    tick(); tick();
    r_valid = 1'b1; r_data = 64'h77; r_last = 1'b0;
    tick();
    r_data = 64'h88; r_last = 1'b1;
    tick();
    r_valid = 1'b0; r_last = 1'b0;
    chk("held_resp", {mem_resp_valid, mem_resp_data},
        {1'b1, 64'h88, 64'h77});
    snap = ar_hs + aw_hs;
    tick(); tick(); tick(); tick();
    chk("held_no_reissue", {ar_valid, aw_valid, 32'(ar_hs + aw_hs - snap)},
        {1'b0, 1'b0, 32'd0});
    mem_req_valid = 1'b0;
    tick(); tick();
    mem_req_valid = 1'b1;
    tick();
    chk("held_reissue", ar_valid, 1'b1);
    tick();
    r_valid = 1'b1; r_data = 64'h99; r_last = 1'b0; r_resp = 2'b00;
    tick();
    chk("err_clear_before", bus_err, 1'b0);
    r_data = 64'hAA; r_last = 1'b1; r_resp = 2'b10;
    tick();
    r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00;
    chk("err_resp", {mem_resp_valid, bus_err, mem_resp_data},
        {1'b1, 1'b1, 64'hAA, 64'h99});
    mem_req_valid = 1'b0;
    tick(); tick(); tick();
    chk("err_sticky", bus_err, 1'b1);

    // Reset in RDATA after beat 0
    mem_req_addr = 32'h8000_3000; mem_req_valid = 1'b1;
    tick(); tick();
    r_valid = 1'b1; r_data = 64'h5555; r_last = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_outs", {r_ready, ar_valid, aw_valid, w_valid, b_ready,
                      mem_resp_valid, bus_err, ar_addr}, '0);
    chk("mrst_data", mem_resp_data, '0);
    r_valid = 1'b0; mem_req_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Post-reset fill, r_last on beat 0
    mem_req_addr = 32'h8000_0040; mem_req_valid = 1'b1;
    tick();
    chk("post_ar", {ar_valid, ar_addr}, {1'b1, 32'h8000_0040});
    tick();
    r_valid = 1'b1; r_data = 64'h3333; r_last = 1'b1;
    tick();
    r_valid = 1'b0; r_last = 1'b0;
    chk("post_short_resp", {mem_resp_valid, mem_resp_data},
        {1'b1, 64'h0, 64'h3333});
    mem_req_valid = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
